// File: rtl/wb_arbiter.sv
// Writeback arbiter: two result producers share one register-file write port.
// Conflicts are resolved round-robin; a scoreboard tracks registers with pending writes.
module wb_arbiter #(
    parameter int unsigned data_width = 32,
    parameter int unsigned reg_num    = 32,
    parameter int unsigned addr_width = $clog2(reg_num),
    parameter bit          zeroreg    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [addr_width-1:0] req0_rd,
    input  logic [data_width-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [addr_width-1:0] req1_rd,
    input  logic [data_width-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [addr_width-1:0] issue_rd,
    output logic                  write_n,
    output logic [addr_width-1:0] wr_rd,
    output logic [data_width-1:0] wr_data,
    output logic [reg_num-1:0]    busy
);

    logic                  ptr_q, ptr_d;
    logic                  write_n_q, write_n_d;
    logic [addr_width-1:0] wr_rd_q, wr_rd_d;
    logic [data_width-1:0] wr_data_q, wr_data_d;
    logic [reg_num-1:0]    busy_q, busy_d;

    logic                  transfer;
    logic [addr_width-1:0] sel_rd;
    logic [data_width-1:0] sel_data;

    function automatic logic is_zero_reg(input logic [addr_width-1:0] rd);
        return zeroreg && (rd == '0);
    endfunction

    // ptr_q names the requester that wins when both are valid.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            req0_ready = req0_valid && (!req1_valid || !ptr_q);
            req1_ready = req1_valid && (!req0_valid || ptr_q);
        end
    end

    assign transfer = req0_ready || req1_ready;
    assign sel_rd   = req1_ready ? req1_rd   : req0_rd;
    assign sel_data = req1_ready ? req1_data : req0_data;

    always_comb begin
        ptr_d     = ptr_q;
        write_n_d = 1'b1;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (transfer) begin
            ptr_d     = req0_ready;
            write_n_d = is_zero_reg(sel_rd);
            wr_rd_d   = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Clear first, then set, so an issue to the register being written keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (!write_n_q && (32'(wr_rd_q) < reg_num)) begin
            busy_d[wr_rd_q] = 1'b0;
        end
        if (issue_valid && !is_zero_reg(issue_rd) && (32'(issue_rd) < reg_num)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 1'b0;
            write_n_q <= 1'b1;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            write_n_q <= write_n_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign write_n = write_n_q;
    assign wr_rd   = wr_rd_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter; drives a zeroreg=0 and a zeroreg=1 copy
// in lockstep and scoreboards their registered outputs against a reference model.
module tb_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req0_valid, req1_valid, issue_valid;
    logic [4:0]  req0_rd, req1_rd, issue_rd;
    logic [31:0] req0_data, req1_data;

    logic        z0_r0, z0_r1, z0_wn, z1_r0, z1_r1, z1_wn;
    logic [4:0]  z0_rd, z1_rd;
    logic [31:0] z0_data, z1_data, z0_busy, z1_busy;

    wb_arbiter #(.zeroreg(1'b0)) u_z0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(z0_r0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(z0_r1),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .write_n(z0_wn), .wr_rd(z0_rd), .wr_data(z0_data), .busy(z0_busy)
    );

    wb_arbiter #(.zeroreg(1'b1)) u_z1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(z1_r0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(z1_r1),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .write_n(z1_wn), .wr_rd(z1_rd), .wr_data(z1_data), .busy(z1_busy)
    );

    typedef struct {
        logic        wn0, wn1;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] busy0, busy1;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: who holds priority, which registers await a write, what gets written.
    int          m_prio = 0;
    bit          m_busy[2][32];
    bit          m_wn[2] = '{1'b1, 1'b1};
    int          m_rd = 0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v0, input int rd0, input logic [31:0] d0,
                         input bit v1, input int rd1, input logic [31:0] d1,
                         input bit iv, input int ird);
        int   g;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; req0_valid = v0; req0_rd = 5'(rd0); req0_data = d0;
        req1_valid = v1; req1_rd = 5'(rd1); req1_data = d1;
        issue_valid = iv; issue_rd = 5'(ird);
        #3;
        if (r) g = -1;
        else if (v0 && v1) g = m_prio;
        else if (v0) g = 0;
        else if (v1) g = 1;
        else g = -1;
        check("req0_ready_z0", 32'(z0_r0), 32'(g == 0));
        check("req1_ready_z0", 32'(z0_r1), 32'(g == 1));
        check("req0_ready_z1", 32'(z1_r0), 32'(g == 0));
        check("req1_ready_z1", 32'(z1_r1), 32'(g == 1));
        for (int z = 0; z < 2; z++) begin
            if (r) begin
                for (int i = 0; i < 32; i++) m_busy[z][i] = 1'b0;
            end else begin
                if (!m_wn[z]) m_busy[z][m_rd] = 1'b0;
                if (iv && !(z == 1 && ird == 0)) m_busy[z][ird] = 1'b1;
            end
        end
        if (r) begin
            m_wn = '{1'b1, 1'b1}; m_rd = 0; m_data = '0; m_prio = 0;
        end else if (g >= 0) begin
            m_rd   = (g == 1) ? rd1 : rd0;
            m_data = (g == 1) ? d1 : d0;
            m_wn[0] = 1'b0;
            m_wn[1] = (m_rd == 0);
            m_prio = 1 - g;
        end else begin
            m_wn = '{1'b1, 1'b1};
        end
        e.wn0 = m_wn[0]; e.wn1 = m_wn[1]; e.rd = 5'(m_rd); e.data = m_data;
        for (int i = 0; i < 32; i++) begin
            e.busy0[i] = m_busy[0][i];
            e.busy1[i] = m_busy[1][i];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_cycle();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: each cycle's registered outputs against what the stimulus one cycle earlier implies.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_n_z0", 32'(z0_wn), 32'(e.wn0));
                check("write_n_z1", 32'(z1_wn), 32'(e.wn1));
                check("wr_rd_z0", 32'(z0_rd), 32'(e.rd));
                check("wr_rd_z1", 32'(z1_rd), 32'(e.rd));
                check("wr_data_z0", z0_data, e.data);
                check("wr_data_z1", z1_data, e.data);
                check("busy_z0", z0_busy, e.busy0);
                check("busy_z1", z1_busy, e.busy1);
            end
        end
    end

    initial begin
        rst = 1'b1; req0_valid = 0; req1_valid = 0; issue_valid = 0;
        req0_rd = '0; req1_rd = '0; issue_rd = '0; req0_data = '0; req1_data = '0;
        for (int z = 0; z < 2; z++) for (int i = 0; i < 32; i++) m_busy[z][i] = 1'b0;

        // Both requesters contending right after reset: 0 first, then alternate.
        reset_cycle();
        reset_cycle();
        for (int i = 0; i < 4; i++) cycle(0, 1, 1 + i, 32'h100 + i, 1, 5 + i, 32'h200 + i, 0, 0);
        idle();

        // Lone requester 1 streams without bubbles.
        cycle(0, 0, 0, 0, 1, 9, 32'hA, 0, 0);
        cycle(0, 0, 0, 0, 1, 10, 32'hB, 0, 0);
        cycle(0, 0, 0, 0, 1, 11, 32'hC, 0, 0);
        idle();

        // Write to r0: accepted, suppressed on the zeroreg copy, priority still advances.
        reset_cycle();
        cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        cycle(0, 1, 2, 32'h22, 1, 3, 32'h33, 0, 0);
        check("zero_write_suppressed", 32'(z1_wn), 32'd1);
        idle();

        // Reissue to r7 in the cycle its write lands keeps it busy.
        reset_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle();
        cycle(0, 1, 7, 32'h77, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
        check("r7_write_n", 32'(z1_wn), 32'd0);
        check("r7_wr_rd", 32'(z1_rd), 32'd7);
        check("r7_busy_during_write", 32'(z1_busy[7]), 32'd1);
        idle();
        check("r7_busy_after", 32'(z1_busy[7]), 32'd1);

        // Reset in the write cycle drops the pending write.
        reset_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3);
        cycle(0, 1, 3, 32'h3333, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("reset_drops_write", 32'(z1_wn), 32'd1);
        check("reset_clears_busy", z1_busy, 32'd0);
        cycle(0, 1, 4, 32'h44, 1, 5, 32'h55, 0, 0);

        // Without a hardwired zero, r0 behaves like any other register.
        reset_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 32'h5, 0, 0, 0, 0, 0);
        check("r0_busy_set_z0", 32'(z0_busy[0]), 32'd1);
        check("r0_busy_ignored_z1", 32'(z1_busy[0]), 32'd0);
        idle();
        check("r0_write_z0", {z0_wn, 26'd0, z0_rd}, 32'd0);
        check("r0_data_z0", z0_data, 32'h5);
        idle();
        check("r0_busy_clear_z0", 32'(z0_busy[0]), 32'd0);

        // Random traffic with occasional resets; register ids biased toward collisions and r0.
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) != 0),
                  int'($urandom_range(0, 7)));
        end
        idle();
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
